mem_rr_responder: RTL and testbench

- Responder end of the per-accessor load/store/done memory interface driven by core_top.
- Serves N_ACCESSORS initiators from one internal word-organised register memory, using a 3-state FSM and a round-robin arbiter.
- Completes one access at a time and returns the result with a single-cycle done pulse to the granted accessor.
- Drop-in arbitrated memory model for multi-accessor core tops.

---
 rtl/mem_rr_responder_if.sv | 24 ++
 rtl/mem_rr_responder.sv | 145 ++++++++++++++
 tb/tb_mem_rr_responder.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_rr_responder_if.sv
// Per-accessor load/store/done bus between core-side initiators and the
// arbitrated memory responder.
interface mem_rr_responder_if #(
    parameter int BITSIZE     = 32,
    parameter int N_ACCESSORS = 2
);
    logic [N_ACCESSORS*BITSIZE-1:0] acc_address_i;
    logic [N_ACCESSORS-1:0]         acc_load_i;
    logic [N_ACCESSORS-1:0]         acc_store_i;
    logic [N_ACCESSORS*BITSIZE-1:0] acc_data_i;
    logic [N_ACCESSORS*BITSIZE-1:0] acc_data_o;
    logic [N_ACCESSORS-1:0]         acc_done_o;
    logic [N_ACCESSORS-1:0]         acc_err_o;

    modport master (
        output acc_address_i, acc_load_i, acc_store_i, acc_data_i,
        input  acc_data_o, acc_done_o, acc_err_o
    );

    modport slave (
        input  acc_address_i, acc_load_i, acc_store_i, acc_data_i,
        output acc_data_o, acc_done_o, acc_err_o
    );
endinterface

// File: rtl/mem_rr_responder.sv
// Round-robin arbitrated word memory serving N_ACCESSORS load/store initiators,
// one access at a time, with a single-cycle done pulse per completed access.
module mem_rr_responder #(
    parameter int BITSIZE     = 32,
    parameter int MEM_SIZE    = 16,
    parameter int N_ACCESSORS = 2
) (
    input  logic                  clk,
    input  logic                  resetn_i,
    mem_rr_responder_if.slave     bus
);
    localparam int AW = $clog2(MEM_SIZE);
    localparam int IW = (N_ACCESSORS > 1) ? $clog2(N_ACCESSORS) : 1;
    localparam logic [BITSIZE-1:0] MEM_BYTES = BITSIZE'(MEM_SIZE * 4);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACCESS  = 2'd1;
    localparam logic [1:0] S_RESPOND = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [IW-1:0]          ptr_q, ptr_d;
    logic [N_ACCESSORS-1:0] mask_q, mask_d;
    logic [IW-1:0]          grant_q, grant_d;
    logic [BITSIZE-1:0]     addr_q, addr_d;
    logic [BITSIZE-1:0]     wdata_q, wdata_d;
    logic                   store_q, store_d;
    logic [BITSIZE-1:0]     mem_q [MEM_SIZE];
    logic [BITSIZE-1:0]     mem_d [MEM_SIZE];
    logic [BITSIZE-1:0]     data_o_q [N_ACCESSORS];
    logic [BITSIZE-1:0]     data_o_d [N_ACCESSORS];
    logic [N_ACCESSORS-1:0] done_q, done_d;
    logic [N_ACCESSORS-1:0] err_o_q, err_o_d;

    logic [N_ACCESSORS-1:0] req;
    logic [BITSIZE-1:0]     addr_a  [N_ACCESSORS];
    logic [BITSIZE-1:0]     wdata_a [N_ACCESSORS];
    logic                   found;
    logic [IW-1:0]          cand;
    int unsigned            pos;
    logic                   in_range;
    logic [AW-1:0]          widx;
    logic [BITSIZE-1:0]     rdata;

    assign req = bus.acc_load_i | bus.acc_store_i;

    for (genvar k = 0; k < N_ACCESSORS; k++) begin : g_slice
        assign addr_a[k]  = bus.acc_address_i[k*BITSIZE +: BITSIZE];
        assign wdata_a[k] = bus.acc_data_i[k*BITSIZE +: BITSIZE];
        assign bus.acc_data_o[k*BITSIZE +: BITSIZE] = data_o_q[k];
    end

    assign bus.acc_done_o = done_q;
    assign bus.acc_err_o  = err_o_q;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        mask_d   = mask_q;
        grant_d  = grant_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        store_d  = store_q;
        mem_d    = mem_q;
        data_o_d = data_o_q;
        done_d   = '0;
        err_o_d  = '0;
        found    = 1'b0;
        cand     = '0;
        pos      = '0;
        rdata    = '0;
        in_range = (addr_q < MEM_BYTES);
        widx     = addr_q[2 +: AW];

        case (state_q)
            S_IDLE: begin
                mask_d = '0;
                // Scan from the pointer with wrap; the just-served accessor is masked for this one cycle.
                for (int unsigned i = 0; i < N_ACCESSORS; i++) begin
                    pos = 32'(ptr_q) + i;
                    if (pos >= N_ACCESSORS) pos = pos - N_ACCESSORS;
                    cand = IW'(pos);
                    if (!found && req[cand] && !mask_q[cand]) begin
                        found   = 1'b1;
                        grant_d = cand;
                    end
                end
                if (found) begin
                    addr_d  = addr_a[grant_d];
                    wdata_d = wdata_a[grant_d];
                    store_d = bus.acc_store_i[grant_d];
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (in_range) begin
                    if (store_q) begin
                        mem_d[widx] = wdata_q;
                        rdata       = wdata_q;
                    end else begin
                        rdata = mem_q[widx];
                    end
                end
                data_o_d[grant_q] = rdata;
                done_d[grant_q]   = 1'b1;
                err_o_d[grant_q]  = !in_range;
                state_d           = S_RESPOND;
            end
            S_RESPOND: begin
                ptr_d           = (grant_q == IW'(N_ACCESSORS - 1)) ? '0 : grant_q + 1'b1;
                mask_d          = '0;
                mask_d[grant_q] = 1'b1;
                state_d         = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            mask_q   <= '0;
            grant_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            store_q  <= 1'b0;
            mem_q    <= '{default: '0};
            data_o_q <= '{default: '0};
            done_q   <= '0;
            err_o_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            mask_q   <= mask_d;
            grant_q  <= grant_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            store_q  <= store_d;
            mem_q    <= mem_d;
            data_o_q <= data_o_d;
            done_q   <= done_d;
            err_o_q  <= err_o_d;
        end
    end
endmodule

// File: tb/tb_mem_rr_responder.sv
// Directed and randomized checks of mem_rr_responder against a cycle-scheduled
// transaction model (grant cycle, done two cycles later, served accessor skipped once).
module tb_mem_rr_responder;
    localparam int BITSIZE  = 32;
    localparam int MEM_SIZE = 16;
    localparam int N        = 2;

    logic clk = 1'b0;
    logic resetn_i = 1'b0;
    always #5 clk = ~clk;

    mem_rr_responder_if #(.BITSIZE(BITSIZE), .N_ACCESSORS(N)) bus ();

    mem_rr_responder #(
        .BITSIZE    (BITSIZE),
        .MEM_SIZE   (MEM_SIZE),
        .N_ACCESSORS(N)
    ) dut (
        .clk     (clk),
        .resetn_i(resetn_i),
        .bus     (bus)
    );

    // Stimulus state per accessor
    logic        ld [N];
    logic        st [N];
    logic [31:0] ad [N];
    logic [31:0] wd [N];

    // Reference model
    logic [31:0] mmem  [MEM_SIZE];
    logic [31:0] mdata [N];
    int unsigned cyc;
    int unsigned ptr;
    int unsigned next_arb;
    int          excl;
    int unsigned excl_cyc;
    bit          pend;
    int unsigned pend_cyc;
    int          pend_acc;
    logic [31:0] pend_data;
    logic        pend_err;

    int n_assert = 0;
    int n_fail   = 0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        for (int k = 0; k < N; k++) begin
            bus.acc_load_i[k]               = ld[k];
            bus.acc_store_i[k]              = st[k];
            bus.acc_address_i[k*32 +: 32]   = ad[k];
            bus.acc_data_i[k*32 +: 32]      = wd[k];
        end
    endtask

    // Decide what the responder does with the requests present in cycle cyc.
    task automatic model_step();
        bit          found;
        int          g;
        int          idx;
        logic [31:0] r;
        logic        e;
        apply();
        if (cyc >= next_arb) begin
            found = 0;
            g = 0;
            for (int i = 0; i < N; i++) begin
                int k;
                k = (int'(ptr) + i) % N;
                if (!found && (ld[k] || st[k]) && !(excl == k && excl_cyc == cyc)) begin
                    found = 1;
                    g = k;
                end
            end
            if (found) begin
                if (ad[g] < MEM_SIZE * 4) begin
                    idx = int'(ad[g] / 4);
                    if (st[g]) begin
                        mmem[idx] = wd[g];
                        r = wd[g];
                    end else begin
                        r = mmem[idx];
                    end
                    e = 1'b0;
                end else begin
                    r = 32'h0;
                    e = 1'b1;
                end
                pend      = 1;
                pend_cyc  = cyc + 2;
                pend_acc  = g;
                pend_data = r;
                pend_err  = e;
                ptr       = (g + 1) % N;
                next_arb  = cyc + 3;
                excl      = g;
                excl_cyc  = cyc + 3;
            end else begin
                next_arb = cyc + 1;
            end
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0]    exp_done;
        logic [N*32-1:0] exp_data;
        exp_done = '0;
        if (pend && pend_cyc == cyc) begin
            exp_done[pend_acc] = 1'b1;
            mdata[pend_acc] = pend_data;
            pend = 0;
            chk("err_at_done", bus.acc_err_o[pend_acc], pend_err);
        end
        for (int k = 0; k < N; k++) exp_data[k*32 +: 32] = mdata[k];
        chk("done_vec", bus.acc_done_o, exp_done);
        chk("data_vec", bus.acc_data_o, exp_data);
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        cyc++;
        check_outputs();
    endtask

    task automatic wait_done(input int k, input int budget, output int unsigned at);
        bit got;
        got = 0;
        at  = cyc;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            if (bus.acc_done_o[k]) begin
                got = 1;
                at  = cyc;
            end
        end
        chk($sformatf("wait_done%0d", k), got, 1);
    endtask

    task automatic do_reset();
        resetn_i = 1'b0;
        for (int k = 0; k < N; k++) begin
            ld[k] = 0; st[k] = 0; ad[k] = '0; wd[k] = '0;
        end
        apply();
        repeat (2) begin
            @(negedge clk);
            cyc++;
        end
        for (int i = 0; i < MEM_SIZE; i++) mmem[i] = '0;
        for (int k = 0; k < N; k++) mdata[k] = '0;
        ptr  = 0;
        pend = 0;
        excl = -1;
        chk("rst_done", bus.acc_done_o, 0);
        chk("rst_data", bus.acc_data_o, 0);
        chk("rst_err",  bus.acc_err_o, 0);
        resetn_i = 1'b1;
        next_arb = cyc;
    endtask

    task automatic new_req(input int k);
        int op;
        op    = $urandom_range(0, 2);
        ld[k] = (op != 1);
        st[k] = (op != 0);
        ad[k] = 32'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
        wd[k] = $urandom;
    endtask

    initial begin
        int unsigned t0, d0, d1, d2;
        int          prev, repeats, ndone;
        logic [31:0] slice;

        cyc = 0;
        do_reset();

        // Single load after reset: 2-cycle latency, zero data
        ld[0] = 1; ad[0] = 32'h8;
        t0 = cyc;
        wait_done(0, 10, d0);
        chk("load_latency", 64'(d0 - t0), 2);
        slice = bus.acc_data_o[31:0];
        chk("load_zero_data", slice, 32'h0);
        chk("load_zero_err", bus.acc_err_o[0], 0);
        ld[0] = 0;

        // Store by accessor 1, then load by accessor 0 sees it
        st[1] = 1; ad[1] = 32'h4; wd[1] = 32'hDEADBEEF;
        wait_done(1, 10, d0);
        slice = bus.acc_data_o[63:32];
        chk("store_ret", slice, 32'hDEADBEEF);
        st[1] = 0;
        ld[0] = 1; ad[0] = 32'h4;
        wait_done(0, 10, d0);
        slice = bus.acc_data_o[31:0];
        chk("load_after_store", slice, 32'hDEADBEEF);
        ld[0] = 0;
        repeat (3) tick();
        slice = bus.acc_data_o[63:32];
        chk("slice1_hold", slice, 32'hDEADBEEF);

        // Simultaneous loads from reset
        do_reset();
        ld[0] = 1; ad[0] = 32'h0;
        ld[1] = 1; ad[1] = 32'h4;
        t0 = cyc;
        wait_done(0, 10, d0);
        chk("both_acc0_cycle", 64'(d0 - t0), 2);
        ld[0] = 0;
        wait_done(1, 10, d1);
        chk("both_acc1_cycle", 64'(d1 - t0), 5);
        ld[1] = 0;
        tick();

        // Both held continuously: grants must alternate
        ld[0] = 1; ld[1] = 1;
        prev = -1; repeats = 0; ndone = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            for (int k = 0; k < N; k++) begin
                if (bus.acc_done_o[k]) begin
                    if (prev == k) repeats++;
                    prev = k;
                    ndone++;
                end
            end
        end
        chk("alt_no_repeat", 64'(repeats), 0);
        chk("alt_throughput", 64'(ndone), 8);
        ld[0] = 0; ld[1] = 0;
        repeat (4) tick();

        // Out-of-range store leaves memory untouched
        st[0] = 1; ad[0] = 32'h0; wd[0] = 32'h00005A5A;
        wait_done(0, 10, d0);
        st[0] = 0;
        tick();
        st[0] = 1; ad[0] = 32'h40; wd[0] = 32'hCAFEF00D;
        wait_done(0, 10, d0);
        chk("oor_err", bus.acc_err_o[0], 1);
        slice = bus.acc_data_o[31:0];
        chk("oor_data", slice, 32'h0);
        st[0] = 0;
        tick();
        ld[0] = 1; ad[0] = 32'h0;
        wait_done(0, 10, d0);
        slice = bus.acc_data_o[31:0];
        chk("oor_mem_intact", slice, 32'h00005A5A);
        chk("oor_load_err", bus.acc_err_o[0], 0);
        ld[0] = 0;
        repeat (3) tick();

        // Reset during ACCESS of a store abandons it
        st[0] = 1; ad[0] = 32'h0; wd[0] = 32'h00001234;
        tick();
        do_reset();
        repeat (4) tick();
        ld[0] = 1; ad[0] = 32'h0;
        wait_done(0, 10, d0);
        slice = bus.acc_data_o[31:0];
        chk("reset_abandon", slice, 32'h0);

        // Held past done: masked for one IDLE cycle, next done 4 cycles after previous
        wait_done(0, 10, d2);
        chk("mask_redone", 64'(d2 - d0), 4);
        ld[0] = 0;
        repeat (3) tick();

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 500; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!(ld[k] || st[k])) begin
                    if ($urandom_range(0, 2) == 0) new_req(k);
                end else if (bus.acc_done_o[k]) begin
                    if ($urandom_range(0, 1) == 0) begin
                        ld[k] = 0; st[k] = 0;
                    end else begin
                        new_req(k);
                    end
                end
            end
            tick();
        end
        for (int k = 0; k < N; k++) begin
            ld[k] = 0; st[k] = 0;
        end
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
